// File: rtl/bet_number_buffer.sv
// Roulette bet-number entry buffer: collects up to four distinct positions (0..7)
// from keypad digits 1..8, with duplicate rejection, clear and confirm handling.
module bet_number_buffer #(
  parameter logic [3:0] NUMBER_INPUT_STATE = 4'd3,
  parameter logic [3:0] KEY_CLEAR          = 4'd11,
  parameter logic [3:0] KEY_CONFIRM        = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic [2:0] bet_count,
  input  logic       clear_input,
  input  logic       reset_round,
  output logic [2:0] user_num0,
  output logic [2:0] user_num1,
  output logic [2:0] user_num2,
  output logic [2:0] user_num3,
  output logic [3:0] slot_valid,
  output logic [2:0] entry_count,
  output logic [1:0] num_store_idx,
  output logic       entry_full,
  output logic       dup_reject,
  output logic       confirm_pulse
);

  logic [2:0] num_r [4];
  logic [2:0] num_s [4];
  logic [3:0] slot_valid_r;
  logic [3:0] slot_valid_s;
  logic [2:0] entry_count_r;
  logic [2:0] entry_count_s;
  logic [3:0] prev_state_r;
  logic       dup_r;
  logic       dup_s;
  logic       confirm_r;
  logic       confirm_s;

  logic [2:0] eff_count_s;
  logic [2:0] last_slot_s;
  logic       entry_edge_s;
  logic       in_entry_s;
  logic       is_digit_s;
  logic [2:0] digit_pos_s;
  logic       dup_hit_s;
  logic       room_s;
  logic       full_s;

  // Clamp the requested bet count into the legal 1..4 range
  always_comb begin
    if (bet_count == 3'd0) begin
      eff_count_s = 3'd1;
    end else if (bet_count > 3'd4) begin
      eff_count_s = 3'd4;
    end else begin
      eff_count_s = bet_count;
    end
  end

  assign last_slot_s  = eff_count_s - 3'd1;
  assign in_entry_s   = (state == NUMBER_INPUT_STATE);
  assign entry_edge_s = in_entry_s && (prev_state_r != NUMBER_INPUT_STATE);
  assign is_digit_s   = (key_value >= 4'd1) && (key_value <= 4'd8);
  // Key 8 wraps to 3'b000 in the low bits, so subtracting one lands on position 7.
  assign digit_pos_s  = key_value[2:0] - 3'd1;
  assign full_s       = (entry_count_r == eff_count_s);
  // An over-full buffer (bet count lowered after entry) also accepts no digits.
  assign room_s       = (entry_count_r < eff_count_s);

  // Compare the pending digit against every occupied slot
  always_comb begin
    dup_hit_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (slot_valid_r[i] && (num_r[i] == digit_pos_s)) begin
        dup_hit_s = 1'b1;
      end else begin
        dup_hit_s = dup_hit_s;
      end
    end
  end

  // Next-state for slots, count and pulses, ordered by event priority
  always_comb begin
    num_s         = num_r;
    slot_valid_s  = slot_valid_r;
    entry_count_s = entry_count_r;
    dup_s         = 1'b0;
    confirm_s     = 1'b0;
    if (reset_round || clear_input || entry_edge_s) begin
      for (int i = 0; i < 4; i++) begin
        num_s[i] = 3'd0;
      end
      slot_valid_s  = 4'd0;
      entry_count_s = 3'd0;
    end else if (key_valid && in_entry_s) begin
      if (key_value == KEY_CLEAR) begin
        for (int i = 0; i < 4; i++) begin
          num_s[i] = 3'd0;
        end
        slot_valid_s  = 4'd0;
        entry_count_s = 3'd0;
      end else if (key_value == KEY_CONFIRM) begin
        if (full_s) begin
          confirm_s = 1'b1;
        end else begin
          confirm_s = 1'b0;
        end
      end else if (is_digit_s && room_s) begin
        if (dup_hit_s) begin
          dup_s = 1'b1;
        end else begin
          num_s[entry_count_r[1:0]]        = digit_pos_s;
          slot_valid_s[entry_count_r[1:0]] = 1'b1;
          entry_count_s                    = entry_count_r + 3'd1;
        end
      end else begin
        dup_s = 1'b0;
      end
    end else begin
      dup_s = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        num_r[i] <= 3'd0;
      end
      slot_valid_r  <= 4'd0;
      entry_count_r <= 3'd0;
      prev_state_r  <= 4'd0;
      dup_r         <= 1'b0;
      confirm_r     <= 1'b0;
    end else begin
      num_r         <= num_s;
      slot_valid_r  <= slot_valid_s;
      entry_count_r <= entry_count_s;
      prev_state_r  <= state;
      dup_r         <= dup_s;
      confirm_r     <= confirm_s;
    end
  end

  // Cursor stops on the last slot once the set is complete
  always_comb begin
    if (entry_count_r < eff_count_s) begin
      num_store_idx = entry_count_r[1:0];
    end else begin
      num_store_idx = last_slot_s[1:0];
    end
  end

  assign user_num0     = num_r[0];
  assign user_num1     = num_r[1];
  assign user_num2     = num_r[2];
  assign user_num3     = num_r[3];
  assign slot_valid    = slot_valid_r;
  assign entry_count   = entry_count_r;
  assign entry_full    = full_s;
  assign dup_reject    = dup_r;
  assign confirm_pulse = confirm_r;

endmodule
